// File: rtl/bus_arb_pkg.sv
// Shared types and default sizing for the shared-serial-bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BUSY,
        RELEASE
    } arb_state_e;

    localparam int unsigned NUM_MASTERS_DEF = 4;
    localparam int unsigned TIMEOUT_LEN_DEF = 4;

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational winner search: first set request at or after i_start,
// searching upward and wrapping past the top index back to 0.
module arb_priority_pick
    import bus_arb_pkg::*;
#(
    parameter int unsigned N    = NUM_MASTERS_DEF,
    parameter int unsigned ID_W = $clog2(NUM_MASTERS_DEF)
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_start,
    output logic [ID_W-1:0] o_idx,
    output logic            o_found
);

    // Two passes: upper segment [start, N) first, then the wrapped segment [0, start).
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!o_found && (j >= 32'(i_start)) && i_req[j]) begin
                o_found = 1'b1;
                o_idx   = ID_W'(j);
            end
        end
        for (int unsigned j = 0; j < N; j++) begin
            if (!o_found && (j < 32'(i_start)) && i_req[j]) begin
                o_found = 1'b1;
                o_idx   = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Central arbiter for the shared serial bus: one-hot registered grant,
// bus-utilization tracking, revocation of unused grants after 2**TIMEOUT_LEN clocks.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin winner selection starting at a
// pointer advanced after each release; when undefined, lowest index wins.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = NUM_MASTERS_DEF,
    parameter int unsigned TIMEOUT_LEN = TIMEOUT_LEN_DEF,
    localparam int unsigned ID_WIDTH   = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] b_request,
    input  logic                   b_util,
    input  logic                   slave_busy,
    output logic [NUM_MASTERS-1:0] b_grant,
    output logic                   grant_valid,
    output logic [ID_WIDTH-1:0]    grant_id,
    output logic                   timeout_pulse
);

    arb_state_e               r_state;
    logic [NUM_MASTERS-1:0]   r_grant;
    logic                     r_grant_valid;
    logic [ID_WIDTH-1:0]      r_grant_id;
    logic                     r_timeout_pulse;
    logic [TIMEOUT_LEN-1:0]   r_cnt;

    logic [ID_WIDTH-1:0]      w_start;
    logic [ID_WIDTH-1:0]      w_pick_idx;
    logic                     w_pick_found;
    logic [NUM_MASTERS-1:0]   w_pick_onehot;
    logic [ID_WIDTH-1:0]      w_next_ptr;

`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_WIDTH-1:0]      r_ptr;
    assign w_start = r_ptr;
`else
    assign w_start = '0;
`endif

    // Pointer follows the last granted master, wrapping at NUM_MASTERS (not a power of two in general).
    assign w_next_ptr = (32'(r_grant_id) == NUM_MASTERS - 1) ? '0 : r_grant_id + ID_WIDTH'(1);

    arb_priority_pick #(
        .N    (NUM_MASTERS),
        .ID_W (ID_WIDTH)
    ) u_pick (
        .i_req   (b_request),
        .i_start (w_start),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    // Decode the winner index into the one-hot grant pattern.
    always_comb begin
        w_pick_onehot = '0;
        for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
            w_pick_onehot[j] = (32'(w_pick_idx) == j);
        end
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_grant         <= '0;
            r_grant_valid   <= 1'b0;
            r_grant_id      <= '0;
            r_timeout_pulse <= 1'b0;
            r_cnt           <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr           <= '0;
`endif
        end else begin
            r_timeout_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_found && !b_util && !slave_busy) begin
                        r_grant       <= w_pick_onehot;
                        r_grant_valid <= 1'b1;
                        r_grant_id    <= w_pick_idx;
                        r_cnt         <= '0;
                        r_state       <= GRANT;
                    end
                end
                GRANT: begin
                    // Bus use wins over both request drop and timeout in the same cycle.
                    if (b_util) begin
                        r_state <= BUSY;
                    end else if (!b_request[r_grant_id]) begin
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_state       <= RELEASE;
                    end else if (r_cnt == '1) begin
                        r_grant         <= '0;
                        r_grant_valid   <= 1'b0;
                        r_timeout_pulse <= 1'b1;
                        r_state         <= RELEASE;
                    end else begin
                        r_cnt <= r_cnt + TIMEOUT_LEN'(1);
                    end
                end
                BUSY: begin
                    if (!b_util) begin
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_state       <= RELEASE;
                    end
                end
                RELEASE: begin
`ifdef ARB_ROUND_ROBIN_EN
                    r_ptr <= w_next_ptr;
`endif
                    r_state <= IDLE;
                end
                default: begin
                    r_grant       <= '0;
                    r_grant_valid <= 1'b0;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^w_next_ptr;
`endif

    assign b_grant       = r_grant;
    assign grant_valid   = r_grant_valid;
    assign grant_id      = r_grant_id;
    assign timeout_pulse = r_timeout_pulse;

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(r_grant));

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter (NUM_MASTERS=4, TIMEOUT_LEN=4).
// The driver pushes one expected grant per transaction; the monitor pops on each
// observed grant and checks id, start cycle, length and timeout pulse.
module tb_bus_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned TMO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] b_request;
    logic       b_util;
    logic       slave_busy;
    logic [3:0] b_grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       timeout_pulse;

    bus_arbiter #(
        .NUM_MASTERS (4),
        .TIMEOUT_LEN (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .b_request     (b_request),
        .b_util        (b_util),
        .slave_busy    (slave_busy),
        .b_grant       (b_grant),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned id;
        int unsigned start;
        int unsigned len;
        bit          tmo;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    int unsigned model_ptr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference winner: rule-level search over the request bits.
    function automatic int unsigned model_pick(input logic [3:0] r);
`ifdef ARB_ROUND_ROBIN_EN
        for (int unsigned i = 0; i < N; i++) begin
            if (r[(model_ptr + i) % N]) return (model_ptr + i) % N;
        end
`else
        for (int unsigned i = 0; i < N; i++) begin
            if (r[i]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction from IDLE with quiet inputs. mode 0: use bus, 1: drop request, 2: timeout.
    task automatic do_txn(input logic [3:0] r, input bit inhib_util, input int unsigned k,
                          input int unsigned mode, input int unsigned d, input int unsigned h,
                          input bit drop_with_util);
        exp_t e;
        e.id    = model_pick(r);
        e.start = cyc + k + 1;
        e.tmo   = (mode == 2);
        case (mode)
            0:       e.len = d + h + 1;
            1:       e.len = d + 1;
            default: e.len = TMO;
        endcase
        sb.push_back(e);

        b_request = r;
        if (k > 0) begin
            if (inhib_util) b_util = 1'b1;
            else            slave_busy = 1'b1;
        end
        repeat (k) step();
        b_util     = 1'b0;
        slave_busy = 1'b0;
        repeat (e.start - cyc) step();

        case (mode)
            0: begin
                repeat (d) step();
                b_util = 1'b1;
                if (drop_with_util) b_request = '0;
                repeat (h) step();
                b_util    = 1'b0;
                b_request = '0;
            end
            1: begin
                repeat (d) step();
                b_request = '0;
            end
            default: begin
                repeat (TMO) step();
                b_request = '0;
            end
        endcase
        repeat (e.start + e.len + 1 - cyc) step();
`ifdef ARB_ROUND_ROBIN_EN
        model_ptr = (e.id + 1) % N;
`endif
    endtask

    // Monitor: pop an expectation on each grant rise, verify through the fall.
    bit          in_g = 1'b0;
    bit          chk_after = 1'b0;
    exp_t        cur;
    int unsigned glen = 0;

    always @(negedge clk) begin
        if (!mon_en) begin
            in_g      = 1'b0;
            chk_after = 1'b0;
        end else begin
            if (chk_after) begin
                check("pulse_one_clock", 32'(timeout_pulse), 0);
                chk_after = 1'b0;
            end
            if (!in_g && b_grant != 4'b0) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_grant: got %b expected none (cycle %0d)", b_grant, cyc);
                    cur.id = 0; cur.start = cyc; cur.len = 0; cur.tmo = 1'b0;
                end else begin
                    cur = sb.pop_front();
                end
                check("grant_start", cyc, cur.start);
                check("grant_onehot", 32'(b_grant), 32'(1) << cur.id);
                check("grant_id", 32'(grant_id), cur.id);
                check("grant_valid_hi", 32'(grant_valid), 1);
                in_g = 1'b1;
                glen = 1;
            end else if (in_g && b_grant != 4'b0) begin
                glen++;
                check("grant_hold", 32'(b_grant), 32'(1) << cur.id);
            end else if (in_g) begin
                check("grant_len", glen, cur.len);
                check("timeout_pulse", 32'(timeout_pulse), 32'(cur.tmo));
                check("grant_valid_lo", 32'(grant_valid), 0);
                check("grant_id_hold", 32'(grant_id), cur.id);
                in_g      = 1'b0;
                chk_after = 1'b1;
            end
        end
    end

    initial begin
        rst        = 1'b1;
        b_request  = '0;
        b_util     = 1'b0;
        slave_busy = 1'b0;
        #1;
        check("rst_grant", 32'(b_grant), 0);
        check("rst_valid", 32'(grant_valid), 0);
        check("rst_id", 32'(grant_id), 0);
        check("rst_pulse", 32'(timeout_pulse), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        mon_en = 1'b1;

        do_txn(4'b0100, 1'b0, 0, 0, 1, 5, 1'b0);
        do_txn(4'b0001, 1'b0, 10, 1, 2, 0, 1'b0);
        do_txn(4'b0010, 1'b0, 0, 2, 0, 0, 1'b0);
        do_txn(4'b1000, 1'b0, 0, 0, 1, 2, 1'b1);
        do_txn(4'b0101, 1'b1, 3, 1, 0, 0, 1'b0);
        repeat (5) do_txn(4'b1011, 1'b0, 0, 0, 0, 3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  r;
            int unsigned m;
            r = 4'($urandom_range(1, 15));
            m = $urandom_range(0, 5);
            m = (m >= 4) ? ((m == 5) ? 2 : 0) : ((m >= 2) ? 1 : 0);
            do_txn(r, 1'($urandom_range(0, 1)), $urandom_range(0, 3), m,
                   $urandom_range(0, 3), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end

        // Leave a nonzero pointer, then reset mid-BUSY.
        do_txn(4'b0010, 1'b0, 0, 1, 1, 0, 1'b0);
        mon_en    = 1'b0;
        b_request = 4'b0100;
        step();
        b_util = 1'b1;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy_grant", 32'(b_grant), 0);
        check("rst_busy_valid", 32'(grant_valid), 0);
        check("rst_busy_id", 32'(grant_id), 0);
        step();
        rst       = 1'b0;
        b_util    = 1'b0;
        b_request = '0;
        step();
        step();
        model_ptr = 0;
        mon_en    = 1'b1;
        do_txn(4'b1111, 1'b0, 0, 1, 1, 0, 1'b0);
        step();
        step();

        check("sb_drained", sb.size(), 0);
        check("grant_closed", 32'(in_g), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
